// File: rtl/rst_pkg.sv
// Shared types and constants for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DONE   = 3'd2,
    ST_ERROR  = 3'd3,
    ST_UNWIND = 3'd4
  } seq_state_t;

  // err_dom is wide enough to name any of up to 8 domains
  localparam int ERR_DOM_W = 3;

  // Counter width covering the longer of the hold and timeout windows
  function automatic int cnt_width(input int hold_cyc, input int tmo_cyc);
    int m;
    m = (hold_cyc > tmo_cyc) ? hold_cyc : tmo_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Reset synchronizer: asserts asynchronously, releases on the second clk rise.
// Latency: two clk edges from rstn release to srstn release.
// Backpressure: none.
module rst_sync_2ff (
  input  logic clk,
  input  logic rstn,
  output logic srstn
);

  logic meta;

  // Shift a constant 1 through two flops once the external reset lets go
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta  <= 1'b0;
      srstn <= 1'b0;
    end else begin
      meta  <= 1'b1;
      srstn <= meta;
    end
  end

endmodule

// File: rtl/reset_seq_ctrl.sv
// Releases NUM_DOM reset domains in order, waiting for each domain's ready.
// Latency: 18 edges to first release, then HOLD_CYC+1 per ready domain.
// Backpressure: none; a missing ready times out into ERROR until sw_rst_req.
module reset_seq_ctrl
  import rst_pkg::*;
#(
  parameter int NUM_DOM  = 4,
  parameter int HOLD_CYC = 16,
  parameter int TMO_CYC  = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sw_rst_req,
  input  logic [NUM_DOM-1:0]   dom_rdy,
  output logic [NUM_DOM-1:0]   dom_rstn,
  output logic                 seq_done,
  output logic                 err,
  output logic [ERR_DOM_W-1:0] err_dom
);

  localparam int CNT_W = cnt_width(HOLD_CYC, TMO_CYC);
  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  logic             srstn;
  logic             run;
  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_sat;
  logic [IDX_W-1:0] drop_idx;

  rst_sync_2ff u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .srstn (srstn)
  );

  // Counter increments but sticks at all-ones instead of wrapping
  assign cnt_sat = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // Lowest-index domain whose ready has dropped
  always_comb begin
    drop_idx = '0;
    for (int j = NUM_DOM - 1; j >= 0; j--) begin
      if (!dom_rdy[j]) drop_idx = IDX_W'(j);
    end
  end

  // One settle cycle after internal reset release before the FSM starts counting
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Sequencer FSM with registered domain resets and status
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state    <= ST_HOLD;
      idx      <= '0;
      cnt      <= '0;
      dom_rstn <= '0;
      seq_done <= 1'b0;
      err      <= 1'b0;
      err_dom  <= '0;
    end else if (run) begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            dom_rstn[idx] <= 1'b1;
            cnt           <= '0;
            state         <= ST_WAIT;
          end else begin
            cnt <= cnt_sat;
          end
        end

        ST_WAIT: begin
          if (dom_rdy[idx]) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              seq_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_HOLD;
            end
          end else if (cnt == TMO_LAST) begin
            dom_rstn[idx] <= 1'b0;
            err           <= 1'b1;
            err_dom       <= ERR_DOM_W'(idx);
            state         <= ST_ERROR;
          end else begin
            cnt <= cnt_sat;
          end
        end

        ST_DONE: begin
          // A software request outranks a simultaneous ready drop
          if (sw_rst_req) begin
            seq_done <= 1'b0;
            idx      <= IDX_LAST;
            state    <= ST_UNWIND;
          end else if (!(&dom_rdy)) begin
            dom_rstn[drop_idx] <= 1'b0;
            seq_done           <= 1'b0;
            err                <= 1'b1;
            err_dom            <= ERR_DOM_W'(drop_idx);
            state              <= ST_ERROR;
          end
        end

        ST_ERROR: begin
          if (sw_rst_req) begin
            err   <= 1'b0;
            idx   <= IDX_LAST;
            state <= ST_UNWIND;
          end
        end

        ST_UNWIND: begin
          // Tear down from the highest domain so lower ones outlive higher ones
          dom_rstn[idx] <= 1'b0;
          if (idx == '0) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end

        default: begin
          idx   <= '0;
          cnt   <= '0;
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl (NUM_DOM=4, HOLD_CYC=16, TMO_CYC=255).
// Edge 0 is the first clk rise after rstn is released on a falling clk edge.
// Outputs are sampled 1 time unit after each rising edge.
module tb_reset_seq_ctrl;

  localparam int ND  = 4;
  localparam int HC  = 16;
  localparam int TC  = 255;
  localparam int INF = 1 << 30;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sw_rst_req;
  logic [3:0] dom_rdy;
  logic [3:0] dom_rstn;
  logic       seq_done;
  logic       err;
  logic [2:0] err_dom;

  int errors = 0;
  int checks = 0;
  int ed     = -1;

  always #5 clk = ~clk;

  reset_seq_ctrl #(
    .NUM_DOM  (ND),
    .HOLD_CYC (HC),
    .TMO_CYC  (TC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sw_rst_req (sw_rst_req),
    .dom_rdy    (dom_rdy),
    .dom_rstn   (dom_rstn),
    .seq_done   (seq_done),
    .err        (err),
    .err_dom    (err_dom)
  );

  typedef struct {
    logic [3:0] rdy;
    int         ev;
    logic [3:0] pre_rstn;
    logic [3:0] post_rstn;
    logic       post_done;
    logic       post_err;
    logic [2:0] post_dom;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string tag, input logic [3:0] e_rstn, input logic e_done,
                     input logic e_err, input logic [2:0] e_dom);
    checks++;
    if ({dom_rstn, seq_done, err, err_dom} !== {e_rstn, e_done, e_err, e_dom}) begin
      errors++;
      $display("FAIL %s edge %0d: got dom_rstn=%b seq_done=%b err=%b err_dom=%0d, need %b %b %b %0d",
               tag, ed, dom_rstn, seq_done, err, err_dom, e_rstn, e_done, e_err, e_dom);
    end
  endtask

  task automatic start_seq();
    rstn       = 1'b0;
    sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    ed   = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic run_to(input int target);
    while (ed < target) step();
  endtask

  // Timeline model: each domain is released at edge t, its ready is sampled from
  // t+1; ready at edge e starts the next hold, released at e+HC; no ready by
  // t+TC is a timeout. mode 0: random ready offsets, 1: always ready,
  // 2: always ready with sw_rst_req pulses while sequencing.
  task automatic rand_trial(input int mode);
    int rise[ND];
    int r[ND];
    int t, e, ev, edom, o;
    bit is_err;
    logic [3:0] e_rstn;
    for (int i = 0; i < ND; i++) begin
      rise[i] = INF;
      r[i]    = INF;
    end
    t = 18;
    ev = 0;
    edom = 0;
    is_err = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (mode != 0)                   o = -100;
      else if ($urandom_range(0, 5) == 0) o = TC + 50;
      else                             o = int'($urandom_range(0, 60)) - 20;
      rise[i] = t;
      r[i]    = t + o;
      e = (r[i] > t + 1) ? r[i] : t + 1;
      if (e > t + TC) begin
        ev = t + TC;
        is_err = 1'b1;
        edom = i;
        break;
      end
      if (i == ND - 1) begin
        ev = e;
        break;
      end
      t = e + HC;
    end
    start_seq();
    for (int k = 0; k <= ev + 4; k++) begin
      for (int i = 0; i < ND; i++) dom_rdy[i] = (k >= r[i]);
      sw_rst_req = (mode != 1) && (k <= ev) &&
                   (($urandom_range(0, 15) == 0) || (mode == 2 && (k == 10 || k == 36)));
      step();
      for (int i = 0; i < ND; i++)
        e_rstn[i] = (k >= rise[i]) && !(is_err && i == edom && k >= ev);
      chk("model", e_rstn, !is_err && k >= ev, is_err && k >= ev,
          (is_err && k >= ev) ? 3'(edom) : 3'd0);
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    rstn       = 1'b1;
    sw_rst_req = 1'b0;
    dom_rdy    = '0;
    #2 rstn = 1'b0;
    #1;
    chk("reset_state", 4'h0, 1'b0, 1'b0, 3'd0);

    // Constant ready patterns: final event edge, state just before and at it
    vt[0] = '{4'hF,    70, 4'hF,    4'hF,    1'b1, 1'b0, 3'd0};
    vt[1] = '{4'b1101, 290, 4'b0011, 4'b0001, 1'b0, 1'b1, 3'd1};
    vt[2] = '{4'b0000, 273, 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd0};
    vt[3] = '{4'b0111, 324, 4'b1111, 4'b0111, 1'b0, 1'b1, 3'd3};
    vt[4] = '{4'b1011, 307, 4'b0111, 4'b0011, 1'b0, 1'b1, 3'd2};
    for (int v = 0; v < 5; v++) begin
      start_seq();
      dom_rdy = vt[v].rdy;
      run_to(vt[v].ev - 1);
      chk("tbl_pre", vt[v].pre_rstn, 1'b0, 1'b0, 3'd0);
      step();
      chk("tbl_post", vt[v].post_rstn, vt[v].post_done, vt[v].post_err, vt[v].post_dom);
    end

    rand_trial(1);
    rand_trial(2);
    repeat (8) rand_trial(0);

    // Software re-sequence from DONE: unwind high to low, then full restart
    start_seq();
    dom_rdy = 4'hF;
    run_to(70);
    chk("done", 4'hF, 1'b1, 1'b0, 3'd0);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("unwind_req", 4'hF, 1'b0, 1'b0, 3'd0);
    step(); chk("unwind_3", 4'h7, 1'b0, 1'b0, 3'd0);
    step(); chk("unwind_2", 4'h3, 1'b0, 1'b0, 3'd0);
    step(); chk("unwind_1", 4'h1, 1'b0, 1'b0, 3'd0);
    step(); chk("unwind_0", 4'h0, 1'b0, 1'b0, 3'd0);
    run_to(90);  chk("reseq_pre", 4'h0, 1'b0, 1'b0, 3'd0);
    step();      chk("reseq_rise", 4'h1, 1'b0, 1'b0, 3'd0);
    run_to(142); chk("reseq_last", 4'hF, 1'b0, 1'b0, 3'd0);
    step();      chk("reseq_done", 4'hF, 1'b1, 1'b0, 3'd0);

    // Software request from ERROR: err clears, err_dom holds, restart
    start_seq();
    dom_rdy = 4'b1101;
    run_to(291);
    chk("err_hold", 4'b0001, 1'b0, 1'b1, 3'd1);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("err_unwind", 4'b0001, 1'b0, 1'b0, 3'd1);
    run_to(295); chk("err_unwind_1", 4'b0001, 1'b0, 1'b0, 3'd1);
    step();      chk("err_unwind_0", 4'b0000, 1'b0, 1'b0, 3'd1);
    run_to(311); chk("err_reseq_pre", 4'b0000, 1'b0, 1'b0, 3'd1);
    step();      chk("err_reseq_rise", 4'b0001, 1'b0, 1'b0, 3'd1);

    // Ready drop in DONE: only the dropped domain goes back into reset
    start_seq();
    dom_rdy = 4'hF;
    run_to(72);
    dom_rdy = 4'b1011;
    step();
    chk("drop2", 4'b1011, 1'b0, 1'b1, 3'd2);
    run_to(76);
    chk("drop2_hold", 4'b1011, 1'b0, 1'b1, 3'd2);

    // Two bits drop together: the lower index is reported
    start_seq();
    dom_rdy = 4'hF;
    run_to(72);
    dom_rdy = 4'b0101;
    step();
    chk("drop_lowest", 4'b1101, 1'b0, 1'b1, 3'd1);

    // Simultaneous drop and software request: request wins
    start_seq();
    dom_rdy = 4'hF;
    run_to(72);
    dom_rdy = 4'b1011;
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("prio_sw", 4'hF, 1'b0, 1'b0, 3'd0);
    step();
    chk("prio_unwind", 4'h7, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-WAIT, then restart from domain 0
    start_seq();
    dom_rdy = 4'b1101;
    run_to(40);
    chk("mid_wait", 4'b0011, 1'b0, 1'b0, 3'd0);
    rstn = 1'b0;
    #1;
    chk("async_rst", 4'h0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    ed = -1;
    dom_rdy = 4'hF;
    run_to(17);
    chk("restart_pre", 4'h0, 1'b0, 1'b0, 3'd0);
    step();
    chk("restart_rise", 4'h1, 1'b0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOM, default 4, number of sequenced reset domains (2..8).
REQ-002 SHALL have parameter HOLD_CYC, default 16, cycles each domain is held in reset before release (>=2).
REQ-003 SHALL have parameter TMO_CYC, default 255, cycles allowed for a domain's ready after release (>=2).
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sw_rst_req  input  1  software re-sequence request, single-cycle pulse.
REQ-007 SHALL have port dom_rdy  input  NUM_DOM  per-domain ready/lock, synchronous to clk.
REQ-008 SHALL have port dom_rstn  output  NUM_DOM  per-domain active-low reset, registered.
REQ-009 SHALL have port seq_done  output  1  all domains released and ready.
REQ-010 SHALL have port err  output  1  sequencing failure flag.
REQ-011 SHALL have port err_dom  output  3  index of the failing domain.

Function
REQ-012 SHALL derive internal srstn from rstn: assertion asynchronous, deassertion after two clk rising edges.
REQ-013 SHALL reset all state and outputs asynchronously on srstn low; the FSM resets into HOLD with index i=0 and cnt=0.
REQ-014 SHALL implement states HOLD, WAIT, DONE, ERROR, UNWIND.
REQ-015 HOLD: all dom_rstn[j>=i] stay 0; cnt increments each cycle; at cnt==HOLD_CYC-1, dom_rstn[i] is set to 1 and the FSM moves to WAIT with cnt=0.
REQ-016 WAIT: only dom_rdy[i] is sampled; if it is 1 and i<NUM_DOM-1, go to HOLD with i+1 and cnt=0; if it is 1 and i==NUM_DOM-1, go to DONE.
REQ-017 WAIT timeout: if dom_rdy[i]==0 at cnt==TMO_CYC-1, go to ERROR; err=1; err_dom=i; dom_rstn[i] is cleared to 0 on the same edge.
REQ-018 ERROR: domains below i keep dom_rstn=1; the state persists until sw_rst_req or reset.
REQ-019 DONE: seq_done=1; if any dom_rdy bit drops, go to ERROR with err_dom = lowest dropped index, clear that dom_rstn bit, and clear seq_done.
REQ-020 sw_rst_req in DONE or ERROR: go to UNWIND; clear seq_done and err on that edge; err_dom holds its last value.
REQ-021 UNWIND: clear dom_rstn bits one per cycle from highest index to 0, then enter HOLD with i=0 and cnt=0.
REQ-022 SHALL ignore sw_rst_req in HOLD, WAIT and UNWIND.
REQ-023 If sw_rst_req coincides with a dom_rdy drop in DONE, SHALL give sw_rst_req priority.
REQ-024 Invariant: dom_rstn[j] never 1 while dom_rstn[k]==0 for any k<j.
REQ-025 cnt width SHALL be clog2(max(HOLD_CYC,TMO_CYC)); it saturates and never wraps.

Reset
REQ-026 rstn low SHALL drive dom_rstn=0 immediately without a clock edge; seq_done=0, err=0, err_dom=0.
REQ-027 rstn asserted mid-sequence SHALL abort the sequence; after release, sequencing restarts from domain 0.

Structure
REQ-028 State encoding and the err_dom width constant SHALL live in shared package rst_pkg.
REQ-029 The two-flop srstn generator SHALL be sub-module rst_sync_2ff, instantiated once.

Verification (NUM_DOM=4, HOLD_CYC=16, TMO_CYC=255; edge 0 = first clk rise after rstn rises)
REQ-030 dom_rdy=4'hF -> dom_rstn bits rise at edges 18, 35, 52, 69; seq_done rises at edge 70; err=0.
REQ-031 dom_rdy[1] stuck at 0 -> dom_rstn[1] rises at edge 35 and falls at edge 290; err=1, err_dom=1; dom_rstn=4'b0001.
REQ-032 In DONE, pulse sw_rst_req -> seq_done=0 next edge; dom_rstn 4'hF->7->3->1->0 one per cycle; then full re-sequence.
REQ-033 dom_rdy[2] drops in DONE -> err=1, err_dom=2, dom_rstn=4'b1011, seq_done=0.
REQ-034 rstn low at edge 40 (mid-WAIT) -> dom_rstn=0 asynchronously; after release, dom_rstn[0] rises 18 edges later.
REQ-035 sw_rst_req pulsed during HOLD and WAIT -> no effect; sequence timing is identical to REQ-030.
